mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle main control FSM for the MIPS core. Sequences fetch/decode/execute/mem/writeback
//  over one shared ALU and one shared memory port. Drives alu_op into ALU_CTRL; ALU_CTRL keeps
//  owning funct decode. Detects jr itself from funct in DECODE.
//  Adds a memory ready handshake with an optional timeout, plus per-instruction done/illegal pulses.
// PARAMETERS
//  MEM_TIMEOUT  0   max wait cycles per memory access; 0 = no timeout
//  TMO_W        8   width of the wait counter; must satisfy MEM_TIMEOUT < 2**TMO_W
// PORTS
//  clk            in   1  sole clock; all state updates on rising edge
//  rst            in   1  synchronous, active-high reset
//  opcode         in   6  instr[31:26] from IR (IR is valid from DECODE onward)
//  funct          in   6  instr[5:0] from IR
//  mem_ready      in   1  memory completes the current read/write in this cycle
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load if ALU zero (datapath ANDs it)
//  pc_source      out  2  00 alu_result, 01 alu_out reg, 10 jump target, 11 rs (jr)
//  i_or_d         out  1  memory address: 0 PC, 1 alu_out
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  IR load
//  reg_write      out  1  register-file write enable
//  reg_dst        out  2  00 rt, 01 rd, 10 $31
//  mem_to_reg     out  2  00 alu_out, 01 MDR, 10 PC (link)
//  alu_src_a      out  1  0 PC, 1 rs
//  alu_src_b      out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op         out  2  00 add, 01 EQ compare, 10 funct decode
//  instr_done     out  1  1-cycle pulse in the final cycle of each instruction
//  illegal_op     out  1  1-cycle pulse in DECODE when the opcode is unsupported
//  mem_err        out  1  1-cycle pulse when a memory wait hits MEM_TIMEOUT
// BEHAVIOUR
//  - While rst=1: all outputs 0, state<=FETCH, wait counter<=0. The first cycle after reset is FETCH.
//  - Unlisted outputs are 0 in each state.
//  - Outputs are Moore, except the mem_ready-qualified signals noted below.
//  FETCH : mem_read, i_or_d=0, src_a=0, src_b=01, alu_op=00, pc_source=00.
//          ir_write=pc_write=mem_ready. mem_ready=1 -> DECODE, else hold.
//  DECODE: src_a=0, src_b=11, alu_op=00 (branch target into alu_out). Next state from opcode:
//          000000 -> JR if funct=001000, else R_EXEC; 100011/101011 -> MEM_ADDR; 000100 -> BRANCH;
//          001000 -> ADDI_EXEC; 000010 -> JUMP; 000011 -> JAL;
//          other -> FETCH, with illegal_op=1 and instr_done=1.
//  MEM_ADDR : src_a=1, src_b=10, op 00 -> MEM_READ (lw) / MEM_WRITE (sw).
//  MEM_READ : mem_read, i_or_d=1. mem_ready -> MEM_WB.
//  MEM_WB   : reg_write, reg_dst=00, mem_to_reg=01, instr_done -> FETCH.
//  MEM_WRITE: mem_write, i_or_d=1. mem_ready -> FETCH, with instr_done=mem_ready.
//  R_EXEC -> R_WB   : R_EXEC src_a=1, src_b=00, op 10; R_WB reg_write, reg_dst=01, done -> FETCH.
//  ADDI_EXEC -> ADDI_WB: ADDI_EXEC src_a=1, src_b=10, op 00; ADDI_WB reg_write, reg_dst=00, done.
//  BRANCH: src_a=1, src_b=00, op 01, pc_write_cond, pc_source=01, done -> FETCH.
//  JUMP  : pc_write, pc_source=10, done.
//  JAL   : JUMP signals + reg_write, reg_dst=10, mem_to_reg=10.
//  JR    : pc_write, pc_source=11, done.
//  Wait states (FETCH, MEM_READ, MEM_WRITE):
//   - counter clears on entry and increments each cycle with mem_ready=0.
//   - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ready=0:
//     mem_err=1, instr_done=1, -> FETCH; no ir/pc/reg write occurs.
//   - A FETCH timeout re-enters FETCH with the counter cleared.
//  - mem_ready=1 on the entry cycle completes the access with 0 wait cycles; mem_ready outside wait states is ignored.
//  - mem_read and mem_write are never both 1.
//  - rst=1 mid-instruction aborts it; no write enable is asserted in that cycle.
//  - Unreachable state encodings -> FETCH.
//  - CPI with zero-wait memory: lw 5, sw 4, R/addi 4, beq/j/jal/jr 3.
// STRUCTURE
//  - Shared package mips_pkg: opcode/funct constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J,
//    OP_JAL, F_JR), ALU_OP_* and PCSRC_*/REGDST_*/M2R_* encodings, state enum ctrl_state_t.
//  - One sub-module: mem_wait_tmr (counter, clear/enable, timeout flag).
//  - Next-state logic and output decode live in the top.
// TESTING
//  1. rst high 3 cycles, then add (op 0, funct 100000), mem_ready=1 -> FETCH, DECODE, R_EXEC, R_WB;
//     R_WB has reg_write=1, reg_dst=01, instr_done=1.
//  2. lw (100011), mem_ready low 2 cycles in MEM_READ -> mem_read, i_or_d=1 held 3 cycles;
//     MEM_WB at cycle 7 with mem_to_reg=01.
//  3. jr (op 0, funct 001000) -> DECODE goes to JR: pc_write=1, pc_source=11; ALU_CTRL-only path untouched.
//  4. opcode 111111 -> illegal_op=1 and instr_done=1 in DECODE; next cycle is FETCH with mem_read=1.
//  5. MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> mem_err pulse on wait cycle 4;
//     ir_write never 1; FETCH re-entered.
//  6. rst asserted in MEM_WRITE -> mem_write=0 that cycle; FETCH on the first post-reset cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, mux
// selects, ALU operation classes, controller state and output bundle.
package mips_pkg;

    // Opcode / funct values recognised by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] F_JR     = 6'b001000;

    // ALU operation class handed to ALU_CTRL (funct decode stays there)
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_EQ    = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // PC source mux
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    // Register-file destination mux
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // Register-file write-data mux
    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    // ALU operand muxes
    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_RS      = 1'b1;
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_ADDI_EXEC = 4'd8,
        S_ADDI_WB   = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13
    } ctrl_state_t;

    // All controller outputs, so the decode can clear them in one assignment
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
        logic       mem_err;
    } ctrl_out_t;

    // States that hold the shared memory port and wait for mem_ready
    function automatic logic is_wait_state(input ctrl_state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
interface mc_ctrl_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_err;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, instr_done, illegal_op, mem_err
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, instr_done, illegal_op, mem_err
    );
endinterface

// File: rtl/mem_wait_tmr.sv
// Memory wait counter: counts cycles spent waiting on mem_ready and flags
// the cycle that would be the MEM_TIMEOUT-th wait.
module mem_wait_tmr #(
    parameter int MEM_TIMEOUT = 0,
    parameter int TMO_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [TMO_W-1:0] cnt,
    output logic             timeout
);
    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // Next count: clear wins, otherwise saturating increment while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

    // cnt_q counts earlier waits, so this cycle is the last allowed one at MEM_TIMEOUT-1
    generate
        if (MEM_TIMEOUT > 0) begin : g_tmo
            localparam logic [TMO_W-1:0] LAST_WAIT = TMO_W'(MEM_TIMEOUT - 1);
            assign timeout = (cnt_q == LAST_WAIT);
        end else begin : g_no_tmo
            assign timeout = 1'b0;
        end
    endgenerate
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main control FSM: fetch/decode/execute/mem/writeback over a
// shared ALU and memory port, with mem_ready waits and optional timeout.
module mc_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0,
    parameter int TMO_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    mc_ctrl_fsm_if.master      bus
);
    ctrl_state_t      state_q;
    ctrl_state_t      state_d;
    ctrl_out_t        out;
    logic             in_wait;
    logic             tmr_en;
    logic             tmr_clr;
    logic             tmr_timeout;
    logic             tmo_hit;
    logic [TMO_W-1:0] tmr_cnt;

    // The wait counter runs only while a wait state is stalled; everything
    // else, including a timeout that re-enters FETCH, restarts it at zero.
    assign in_wait = is_wait_state(state_q);
    assign tmr_en  = in_wait && !bus.mem_ready;
    assign tmo_hit = tmr_en && tmr_timeout;
    assign tmr_clr = !tmr_en || tmo_hit;

    mem_wait_tmr #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMO_W       (TMO_W)
    ) u_tmr (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .cnt     (tmr_cnt),
        .timeout (tmr_timeout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; rst forces every output low
    always_comb begin
        state_d = state_q;
        out     = '0;
        case (state_q)
            S_FETCH: begin
                out.mem_read  = 1'b1;
                out.i_or_d    = 1'b0;
                out.alu_src_a = SRCA_PC;
                out.alu_src_b = SRCB_FOUR;
                out.alu_op    = ALU_OP_ADD;
                out.pc_source = PCSRC_ALU;
                if (bus.mem_ready) begin
                    out.ir_write = 1'b1;
                    out.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end else if (tmo_hit) begin
                    out.mem_err    = 1'b1;
                    out.instr_done = 1'b1;
                    state_d        = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed into alu_out here
                out.alu_src_a = SRCA_PC;
                out.alu_src_b = SRCB_IMM_SH2;
                out.alu_op    = ALU_OP_ADD;
                case (bus.opcode)
                    OP_RTYPE: state_d = (bus.funct == F_JR) ? S_JR : S_R_EXEC;
                    OP_LW,
                    OP_SW:    state_d = S_MEM_ADDR;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_ADDI:  state_d = S_ADDI_EXEC;
                    OP_J:     state_d = S_JUMP;
                    OP_JAL:   state_d = S_JAL;
                    default: begin
                        out.illegal_op = 1'b1;
                        out.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                out.alu_src_a = SRCA_RS;
                out.alu_src_b = SRCB_IMM;
                out.alu_op    = ALU_OP_ADD;
                state_d       = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                out.mem_read = 1'b1;
                out.i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (tmo_hit) begin
                    out.mem_err    = 1'b1;
                    out.instr_done = 1'b1;
                    state_d        = S_FETCH;
                end
            end
            S_MEM_WB: begin
                out.reg_write  = 1'b1;
                out.reg_dst    = REGDST_RT;
                out.mem_to_reg = M2R_MDR;
                out.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WRITE: begin
                out.mem_write = 1'b1;
                out.i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    out.instr_done = 1'b1;
                    state_d        = S_FETCH;
                end else if (tmo_hit) begin
                    out.mem_err    = 1'b1;
                    out.instr_done = 1'b1;
                    state_d        = S_FETCH;
                end
            end
            S_R_EXEC: begin
                out.alu_src_a = SRCA_RS;
                out.alu_src_b = SRCB_RT;
                out.alu_op    = ALU_OP_FUNCT;
                state_d       = S_R_WB;
            end
            S_R_WB: begin
                out.reg_write  = 1'b1;
                out.reg_dst    = REGDST_RD;
                out.mem_to_reg = M2R_ALU;
                out.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_ADDI_EXEC: begin
                out.alu_src_a = SRCA_RS;
                out.alu_src_b = SRCB_IMM;
                out.alu_op    = ALU_OP_ADD;
                state_d       = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                out.reg_write  = 1'b1;
                out.reg_dst    = REGDST_RT;
                out.mem_to_reg = M2R_ALU;
                out.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                out.alu_src_a     = SRCA_RS;
                out.alu_src_b     = SRCB_RT;
                out.alu_op        = ALU_OP_EQ;
                out.pc_write_cond = 1'b1;
                out.pc_source     = PCSRC_ALUOUT;
                out.instr_done    = 1'b1;
                state_d           = S_FETCH;
            end
            S_JUMP: begin
                out.pc_write   = 1'b1;
                out.pc_source  = PCSRC_JUMP;
                out.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_JAL: begin
                out.pc_write   = 1'b1;
                out.pc_source  = PCSRC_JUMP;
                out.reg_write  = 1'b1;
                out.reg_dst    = REGDST_RA;
                out.mem_to_reg = M2R_PC;
                out.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_JR: begin
                out.pc_write   = 1'b1;
                out.pc_source  = PCSRC_RS;
                out.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        if (rst) begin
            out = '0;
        end
    end

    assign bus.pc_write      = out.pc_write;
    assign bus.pc_write_cond = out.pc_write_cond;
    assign bus.pc_source     = out.pc_source;
    assign bus.i_or_d        = out.i_or_d;
    assign bus.mem_read      = out.mem_read;
    assign bus.mem_write     = out.mem_write;
    assign bus.ir_write      = out.ir_write;
    assign bus.reg_write     = out.reg_write;
    assign bus.reg_dst       = out.reg_dst;
    assign bus.mem_to_reg    = out.mem_to_reg;
    assign bus.alu_src_a     = out.alu_src_a;
    assign bus.alu_src_b     = out.alu_src_b;
    assign bus.alu_op        = out.alu_op;
    assign bus.instr_done    = out.instr_done;
    assign bus.illegal_op    = out.illegal_op;
    assign bus.mem_err       = out.mem_err;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed vector bench for mc_ctrl_fsm (built with MEM_TIMEOUT=4).
module tb_mc_ctrl_fsm;
    logic clk;
    logic rst;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(
        .MEM_TIMEOUT (4),
        .TMO_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs, field order:
    // pcw pcwc pcs iod mr mw irw rw rdst m2r srca srcb aluop done ill err
    function automatic logic [21:0] ov(
        input logic pcw, input logic pcwc, input logic [1:0] pcs, input logic iod,
        input logic mr, input logic mw, input logic irw, input logic rw,
        input logic [1:0] rd, input logic [1:0] m2r, input logic sa,
        input logic [1:0] sb, input logic [1:0] aop,
        input logic done, input logic ill, input logic err);
        return {pcw, pcwc, pcs, iod, mr, mw, irw, rw, rd, m2r, sa, sb, aop, done, ill, err};
    endfunction

    logic [21:0] e_zero, e_f_rdy, e_f_wait, e_f_tmo, e_dec, e_dec_ill, e_maddr;
    logic [21:0] e_mread, e_mr_tmo, e_mwb, e_mwrite, e_mw_done, e_rexec, e_rwb;
    logic [21:0] e_awb, e_br, e_jmp, e_jal, e_jr;

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        rdy;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy, input logic [21:0] exp);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, compare on the falling edge, advance past the next rising edge
    task automatic step(input string name, input logic r, input logic [5:0] op,
                        input logic [5:0] fn, input logic rdy, input logic [21:0] exp);
        logic [21:0] act;
        rst           = r;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.mem_ready = rdy;
        @(negedge clk);
        act = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read,
               bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
               bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.instr_done, bus.illegal_op,
               bus.mem_err};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: outputs got %b expected %b", name, act, exp);
        end else begin
            $display("ok   %s: outputs %b", name, act);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        e_zero    = '0;
        e_f_rdy   = ov(1,0,2'd0,0,1,0,1,0,2'd0,2'd0,0,2'd1,2'd0,0,0,0);
        e_f_wait  = ov(0,0,2'd0,0,1,0,0,0,2'd0,2'd0,0,2'd1,2'd0,0,0,0);
        e_f_tmo   = ov(0,0,2'd0,0,1,0,0,0,2'd0,2'd0,0,2'd1,2'd0,1,0,1);
        e_dec     = ov(0,0,2'd0,0,0,0,0,0,2'd0,2'd0,0,2'd3,2'd0,0,0,0);
        e_dec_ill = ov(0,0,2'd0,0,0,0,0,0,2'd0,2'd0,0,2'd3,2'd0,1,1,0);
        e_maddr   = ov(0,0,2'd0,0,0,0,0,0,2'd0,2'd0,1,2'd2,2'd0,0,0,0);
        e_mread   = ov(0,0,2'd0,1,1,0,0,0,2'd0,2'd0,0,2'd0,2'd0,0,0,0);
        e_mr_tmo  = ov(0,0,2'd0,1,1,0,0,0,2'd0,2'd0,0,2'd0,2'd0,1,0,1);
        e_mwb     = ov(0,0,2'd0,0,0,0,0,1,2'd0,2'd1,0,2'd0,2'd0,1,0,0);
        e_mwrite  = ov(0,0,2'd0,1,0,1,0,0,2'd0,2'd0,0,2'd0,2'd0,0,0,0);
        e_mw_done = ov(0,0,2'd0,1,0,1,0,0,2'd0,2'd0,0,2'd0,2'd0,1,0,0);
        e_rexec   = ov(0,0,2'd0,0,0,0,0,0,2'd0,2'd0,1,2'd0,2'd2,0,0,0);
        e_rwb     = ov(0,0,2'd0,0,0,0,0,1,2'd1,2'd0,0,2'd0,2'd0,1,0,0);
        e_awb     = ov(0,0,2'd0,0,0,0,0,1,2'd0,2'd0,0,2'd0,2'd0,1,0,0);
        e_br      = ov(0,1,2'd1,0,0,0,0,0,2'd0,2'd0,1,2'd0,2'd1,1,0,0);
        e_jmp     = ov(1,0,2'd2,0,0,0,0,0,2'd0,2'd0,0,2'd0,2'd0,1,0,0);
        e_jal     = ov(1,0,2'd2,0,0,0,0,1,2'd2,2'd2,0,2'd0,2'd0,1,0,0);
        e_jr      = ov(1,0,2'd3,0,0,0,0,0,2'd0,2'd0,0,2'd0,2'd0,1,0,0);

        // Reset held 3 cycles (mem_ready high must not leak through)
        for (int i = 0; i < 3; i++) add(1, 6'h00, 6'h20, 1, e_zero);
        // add: FETCH, DECODE, R_EXEC, R_WB (mem_ready outside waits ignored)
        add(0, 6'h00, 6'h20, 1, e_f_rdy);
        add(0, 6'h00, 6'h20, 0, e_dec);
        add(0, 6'h00, 6'h20, 1, e_rexec);
        add(0, 6'h00, 6'h20, 0, e_rwb);
        // lw with two MEM_READ wait cycles; MEM_WB on cycle 7
        add(0, 6'h23, 6'h00, 1, e_f_rdy);
        add(0, 6'h23, 6'h00, 1, e_dec);
        add(0, 6'h23, 6'h00, 1, e_maddr);
        add(0, 6'h23, 6'h00, 0, e_mread);
        add(0, 6'h23, 6'h00, 0, e_mread);
        add(0, 6'h23, 6'h00, 1, e_mread);
        add(0, 6'h23, 6'h00, 0, e_mwb);
        // jr
        add(0, 6'h00, 6'h08, 1, e_f_rdy);
        add(0, 6'h00, 6'h08, 1, e_dec);
        add(0, 6'h00, 6'h08, 1, e_jr);
        // illegal opcode, then FETCH of the following sw
        add(0, 6'h3f, 6'h00, 1, e_f_rdy);
        add(0, 6'h3f, 6'h00, 1, e_dec_ill);
        add(0, 6'h2b, 6'h00, 1, e_f_rdy);
        add(0, 6'h2b, 6'h00, 1, e_dec);
        add(0, 6'h2b, 6'h00, 1, e_maddr);
        add(0, 6'h2b, 6'h00, 0, e_mwrite);
        add(0, 6'h2b, 6'h00, 1, e_mw_done);
        // addi with one FETCH wait
        add(0, 6'h08, 6'h00, 0, e_f_wait);
        add(0, 6'h08, 6'h00, 1, e_f_rdy);
        add(0, 6'h08, 6'h00, 1, e_dec);
        add(0, 6'h08, 6'h00, 1, e_maddr);
        add(0, 6'h08, 6'h00, 1, e_awb);
        // beq, j, jal
        add(0, 6'h04, 6'h00, 1, e_f_rdy);
        add(0, 6'h04, 6'h00, 1, e_dec);
        add(0, 6'h04, 6'h00, 1, e_br);
        add(0, 6'h02, 6'h00, 1, e_f_rdy);
        add(0, 6'h02, 6'h00, 1, e_dec);
        add(0, 6'h02, 6'h00, 1, e_jmp);
        add(0, 6'h03, 6'h00, 1, e_f_rdy);
        add(0, 6'h03, 6'h00, 1, e_dec);
        add(0, 6'h03, 6'h00, 1, e_jal);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec[%0d]", i), vecs[i].rst, vecs[i].op, vecs[i].fn,
                 vecs[i].rdy, vecs[i].exp);
        end

        // FETCH timeout twice in a row: error on the 4th wait, counter restarts
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) step($sformatf("ftmo%0d_wait%0d", k, i + 1), 0, 6'h23, 6'h00, 0, e_f_wait);
            step($sformatf("ftmo%0d_err", k), 0, 6'h23, 6'h00, 0, e_f_tmo);
        end

        // lw whose MEM_READ times out, then returns to FETCH
        step("lw_fetch", 0, 6'h23, 6'h00, 1, e_f_rdy);
        step("lw_dec",   0, 6'h23, 6'h00, 1, e_dec);
        step("lw_addr",  0, 6'h23, 6'h00, 1, e_maddr);
        for (int i = 0; i < 3; i++) step($sformatf("lw_rd_wait%0d", i + 1), 0, 6'h23, 6'h00, 0, e_mread);
        step("lw_rd_tmo", 0, 6'h23, 6'h00, 0, e_mr_tmo);

        // Reset during MEM_WRITE: no write that cycle, FETCH right after
        step("sw_fetch",   0, 6'h2b, 6'h00, 1, e_f_rdy);
        step("sw_dec",     0, 6'h2b, 6'h00, 1, e_dec);
        step("sw_addr",    0, 6'h2b, 6'h00, 1, e_maddr);
        step("sw_rst",     1, 6'h2b, 6'h00, 1, e_zero);
        step("post_rst_f", 0, 6'h2b, 6'h00, 0, e_f_wait);
        step("post_rst_r", 0, 6'h2b, 6'h00, 1, e_f_rdy);
        step("post_rst_d", 0, 6'h2b, 6'h00, 1, e_dec);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
